fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h00000000: fetch PC loaded on reset.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port redirect, input, 1: taken branch or jump from the MEM stage; flushes the buffer.
REQ-006 Port redirect_pc, input, 32: new fetch target, qualified by redirect.
REQ-007 Port mem_busy, input, 1: the data side owns the shared memory port this cycle.
REQ-008 Port imem_req, output, 1: instruction read request to the shared memory.
REQ-009 Port imem_addr, output, 8: word-aligned byte address, equal to fetch PC[7:0].
REQ-010 Port imem_rdata, input, 32: read data, valid exactly one cycle after an accepted request.
REQ-011 Port id_valid, output, 1: head entry is valid toward the IF/ID register.
REQ-012 Port id_inst, output, 32: head instruction.
REQ-013 Port id_pc, output, 32: PC of the head instruction.
REQ-014 Port id_ready, input, 1: decode accepts the head this cycle.

Function
REQ-015 A request SHALL be accepted when imem_req=1 and mem_busy=0; fetch PC SHALL then advance by 4, wrapping modulo 2^32.
REQ-016 imem_req SHALL be 1 only if redirect=0, rst=0, and (occupancy + in-flight) < DEPTH.
REQ-017 One cycle after acceptance, imem_rdata and its PC SHALL be written at the tail, unless the request was squashed (REQ-021).
REQ-018 A pop SHALL occur when id_valid=1 and id_ready=1; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-019 Latency SHALL be 2 cycles from acceptance to id_valid when the buffer is empty.
REQ-020 Pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be clog2(DEPTH)+1 bits wide; the buffer SHALL never overflow or underflow.
REQ-021 On redirect=1, the next edge SHALL:
- empty the buffer;
- squash any in-flight response;
- load fetch PC with {redirect_pc[31:2],2'b00}.
REQ-022 Redirect SHALL take priority over a simultaneous push, pop or issue; id_valid SHALL be 0 in the cycle after redirect.
REQ-023 When id_valid=0, id_inst SHALL be 32'h00000013 (NOP) and id_pc SHALL be 0.
REQ-024 In-order delivery SHALL be preserved; no entry is duplicated or dropped except by flush.
REQ-025 When mem_busy=1, no request SHALL be accepted and fetch PC SHALL hold.

Reset
REQ-026 rst=1 SHALL immediately force:
- fetch PC=RESET_PC;
- occupancy=0, pointers=0, in-flight=0;
- id_valid=0, imem_req=0, id_inst=NOP, id_pc=0.
REQ-027 A reset asserted mid-request SHALL discard that response; the first request after release SHALL address RESET_PC.

Configuration
REQ-028 With FETCH_BUF_BYPASS_EN defined: when the buffer is empty and a non-squashed response arrives, it SHALL be presented on id_* in that same cycle. Latency becomes 1 cycle, and the response is not written into the buffer if it is popped that cycle.
REQ-029 With FETCH_BUF_BYPASS_EN undefined: no bypass path exists, and all responses pass through storage (REQ-019).

Verification
REQ-030 Reset release, mem_busy=0, id_ready=1 -> addresses 0x00,0x04,0x08 on consecutive cycles; id_valid first high 2 cycles after first accept (1 with bypass); id_pc sequence 0,4,8.
REQ-031 id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 accepts; then imem_req=0; no further fetch-PC change.
REQ-032 Response for PC 0x10 in flight, redirect=1 with redirect_pc=0x42 -> 0x10 response discarded; next imem_addr=0x40; id_valid=0 for the following cycle.
REQ-033 mem_busy=1 on alternate cycles -> imem_addr advances only on non-busy cycles; delivered PCs contiguous with no gaps or repeats.
REQ-034 Buffer full with push and pop in the same cycle -> occupancy stays 4; order preserved.
REQ-035 rst asserted with 3 entries held -> id_valid drops immediately; after release, first id_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Instruction fetch buffer sitting between the shared instruction/data
// memory port and the IF/ID register. It issues one word read per cycle
// whenever the data side leaves the port free and there is room for the
// response, queues the returned words together with their PCs, and hands
// them to decode in program order. A redirect from MEM flushes everything
// (queued entries and the response still in flight) and restarts fetch at
// the new target.
//
// Build option: define FETCH_BUF_BYPASS_EN to let a response that arrives
// while the queue is empty go straight to id_* in the same cycle.
//
// Parameters
//   DEPTH       number of queue entries (power of two, >= 2)
//   RESET_PC    fetch PC loaded by reset
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   redirect, redirect_pc taken branch/jump from MEM and its target
//   mem_busy              data side owns the memory port this cycle
//   imem_req, imem_addr   read request and byte address (fetch PC[7:0])
//   imem_rdata            read data, one cycle after an accepted request
//   id_valid, id_inst,    head entry toward decode (NOP / PC 0 when empty)
//   id_pc
//   id_ready              decode takes the head this cycle

module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        mem_busy,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h00000013;

    logic [31:0]   r_pc;
    logic [31:0]   r_flightPc;
    logic          r_inFlight;
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instQ [DEPTH];
    logic [31:0]   r_pcQ   [DEPTH];

    logic [CW-1:0] w_occupancy;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_popStore;
    logic          w_bypass;
    logic          w_headValid;
    logic [1:0]    w_unused;

    // Targets are forced word-aligned, so the low bits are never looked at.
    assign w_unused = redirect_pc[1:0];

    // The outstanding response is counted as occupied so that it always has
    // a slot to land in; this is what keeps the queue from overflowing.
    assign w_occupancy = r_count + CW'(r_inFlight);
    assign imem_req    = !rst && !redirect && (w_occupancy < DEPTH_C);
    assign imem_addr   = r_pc[7:0];
    assign w_accept    = imem_req && !mem_busy;

`ifdef FETCH_BUF_BYPASS_EN
    // An arriving response may be shown directly only when nothing older is
    // queued; during a redirect it is about to be squashed, so hide it.
    assign w_bypass = r_inFlight && (r_count == '0) && !redirect;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_headValid = (r_count != '0) || w_bypass;
    assign w_pop       = w_headValid && id_ready && !redirect;
    // A bypassed response that decode consumes immediately never touches
    // storage; in that case the stored head (there is none) is not popped.
    assign w_popStore  = w_pop && !w_bypass;
    assign w_push      = r_inFlight && !redirect && !(w_bypass && w_pop);

    // Head presentation: NOP with PC 0 whenever nothing valid is available.
    always_comb begin
        id_valid = w_headValid;
        id_inst  = NOP;
        id_pc    = '0;
        if (w_bypass) begin
            id_inst = imem_rdata;
            id_pc   = r_flightPc;
        end else if (w_headValid) begin
            id_inst = r_instQ[r_rdPtr];
            id_pc   = r_pcQ[r_rdPtr];
        end
    end

    // Control state: fetch PC, in-flight tracking, pointers and occupancy.
    // A redirect overrides any push, pop or issue in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_flightPc <= '0;
            r_inFlight <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_inFlight <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_pc       <= r_pc + 32'd4;
                r_flightPc <= r_pc;
            end
            r_inFlight <= w_accept;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_popStore) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_popStore) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_popStore) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instQ[r_wrPtr] <= imem_rdata;
            r_pcQ[r_wrPtr]   <= r_flightPc;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
// Directed bench for fetch_buffer with default parameters (DEPTH=4,
// RESET_PC=0). A tiny memory model returns {24'hC0DE5A, address} one cycle
// after each request so returned instructions can be tied back to PCs.

module tb_fetch_buffer;

`ifdef FETCH_BUF_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_busy    = 1'b0;
    logic        id_ready    = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    logic [7:0]  lastAddr    = 8'h00;
    int          checks      = 0;
    int          errors      = 0;
    int          acceptCount = 0;

    fetch_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_busy    (mem_busy),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    // Memory model: data for an address appears in the following cycle.
    always @(posedge clk) begin
        lastAddr <= imem_addr;
    end
    assign imem_rdata = {24'hC0DE5A, lastAddr};

    // Count accepted requests so stall behaviour can be checked in totals.
    always @(posedge clk) begin
        if (!rst && imem_req && !mem_busy) begin
            acceptCount <= acceptCount + 1;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [31:0] rpc,
                                 input logic busy, input logic rdy);
        redirect    = rd;
        redirect_pc = rpc;
        mem_busy    = busy;
        id_ready    = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        int snap;
        int deliveries;
        logic [31:0] expPc;

        // Reset state
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", id_valid, 32'd0);
        checkOutput("rst_req", imem_req, 32'd0);
        checkOutput("rst_inst", id_inst, NOP);
        checkOutput("rst_pc", id_pc, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'd0);

        // Streaming from reset
        rst = 1'b0;
        #1;
        checkOutput("A_req0", imem_req, 32'd1);
        checkOutput("A_addr0", imem_addr, 32'h00);
        checkOutput("A_valid0", id_valid, 32'd0);
        for (int c = 1; c <= LAT + 2; c++) begin
            stepCycle();
            if (c <= 2) checkOutput("A_addr", imem_addr, 32'(4 * c));
            if (c < LAT) checkOutput("A_valid_lat", id_valid, 32'd0);
            if (c >= LAT) begin
                checkOutput("A_valid", id_valid, 32'd1);
                checkOutput("A_pc", id_pc, 32'(4 * (c - LAT)));
                checkOutput("A_inst", id_inst, {24'hC0DE5A, 8'(4 * (c - LAT))});
            end
        end

        // Decode stalled: exactly DEPTH accepts, then fetch stops
        stepCycle();
        applyStimulus(1'b1, 32'h180, 1'b0, 1'b0);
        checkOutput("B_req_redirect", imem_req, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("B_valid_post_redirect", id_valid, 32'd0);
        checkOutput("B_addr_target", imem_addr, 32'h80);
        snap = acceptCount;
        repeat (10) stepCycle();
        checkOutput("B_accepts", 32'(acceptCount - snap), 32'd4);
        checkOutput("B_req_full", imem_req, 32'd0);
        checkOutput("B_addr_held", imem_addr, 32'h90);
        checkOutput("B_head_pc", id_pc, 32'h180);

        // Drain from full while refilling: order must be contiguous
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("C_req_full", imem_req, 32'd0);
        for (int e = 1; e <= 6; e++) begin
            stepCycle();
            checkOutput("C_valid", id_valid, 32'd1);
            checkOutput("C_pc", id_pc, 32'(32'h180 + 4 * e));
            checkOutput("C_inst", id_inst, {24'hC0DE5A, 8'(8'h80 + 4 * e)});
        end

        // Redirect while the 0x10 response is in flight
        stepCycle();
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("D_addr_10", imem_addr, 32'h10);
        stepCycle();
        applyStimulus(1'b1, 32'h42, 1'b0, 1'b1);
        checkOutput("D_req_redirect", imem_req, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("D_valid_after", id_valid, 32'd0);
        checkOutput("D_addr_40", imem_addr, 32'h40);
        for (int f = 1; f <= LAT; f++) begin
            stepCycle();
            if (f < LAT) checkOutput("D_valid_lat", id_valid, 32'd0);
            if (f == LAT) begin
                checkOutput("D_valid", id_valid, 32'd1);
                checkOutput("D_pc", id_pc, 32'h40);
                checkOutput("D_inst", id_inst, {24'hC0DE5A, 8'h40});
            end
        end

        // Data side busy on alternate cycles
        stepCycle();
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        stepCycle();
        expPc      = 32'h20;
        deliveries = 0;
        for (int g = 0; g < 12; g++) begin
            if (g > 0) stepCycle();
            applyStimulus(1'b0, 32'h0, (g % 2) == 1, 1'b1);
            checkOutput("E_addr", imem_addr, 32'(8'h20 + 4 * ((g + 1) / 2)));
            if (id_valid) begin
                checkOutput("E_pc", id_pc, expPc);
                expPc = expPc + 32'd4;
                deliveries++;
            end
        end
        checkOutput("E_deliveries", 32'(deliveries), (LAT == 2) ? 32'd5 : 32'd6);

        // Reset with three entries held and one response in flight
        stepCycle();
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) stepCycle();
        checkOutput("F_valid_held", id_valid, 32'd1);
        checkOutput("F_pc_held", id_pc, 32'h80);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("F_valid_rst", id_valid, 32'd0);
        checkOutput("F_req_rst", imem_req, 32'd0);
        checkOutput("F_inst_rst", id_inst, NOP);
        checkOutput("F_pc_rst", id_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        id_ready = 1'b1;
        #1;
        checkOutput("F_addr_release", imem_addr, 32'h00);
        checkOutput("F_req_release", imem_req, 32'd1);
        checkOutput("F_valid_release", id_valid, 32'd0);
        for (int c = 1; c <= LAT; c++) begin
            stepCycle();
            if (c < LAT) checkOutput("F_valid_lat", id_valid, 32'd0);
            if (c == LAT) begin
                checkOutput("F_valid_first", id_valid, 32'd1);
                checkOutput("F_pc_first", id_pc, 32'd0);
                checkOutput("F_inst_first", id_inst, {24'hC0DE5A, 8'h00});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
